data_memory_ctrl: RTL and testbench

//   Clocked, parametrised RV32 data memory for the MEM stage. It supersedes the combinational word-only data memory.

---
 rtl/data_memory_ctrl_if.sv | 25 ++
 rtl/data_memory_ctrl.sv | 153 +++++++++++++++
 tb/tb_data_memory_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the MEM stage and the data memory controller.
interface data_memory_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        resp_valid;
  logic [31:0] read_data;
  logic        misaligned;
  logic        out_of_range;
  logic        init_done;

  modport master (
    output req_valid, mem_read, mem_write, funct3, address, write_data,
    input  req_ready, resp_valid, read_data, misaligned, out_of_range, init_done
  );

  modport slave (
    input  req_valid, mem_read, mem_write, funct3, address, write_data,
    output req_ready, resp_valid, read_data, misaligned, out_of_range, init_done
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// RV32 data memory: byte/half/word loads and stores, 1-cycle registered response,
// alignment/range checking and a hardware clear of the array after reset.
module data_memory_ctrl #(
  parameter int          DEPTH_WORDS = 256,
  parameter bit          INIT_CLEAR  = 1'b1,
  parameter logic [31:0] OOB_VALUE   = 32'hDEADBEEF
) (
  input  logic               clk,
  input  logic               reset,
  data_memory_ctrl_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             clr_we;
  logic             req_ready;

  logic [31:0]      mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0] widx;
  logic             oob;
  logic             mis;
  logic [3:0]       be;
  logic [31:0]      wlane;
  logic             accept;
  logic             st_we;
  logic [31:0]      rd_word;
  logic [31:0]      resp_data;

  logic             resp_vld_q;
  logic [31:0]      rdata_q;
  logic             mis_q;
  logic             oob_q;

  function automatic logic [31:0] load_ext(input logic [31:0] word,
                                           input logic [2:0]  f3,
                                           input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'b0, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'b0, h};
      default: load_ext = word;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // INIT walks the clear counter across the array once; RUN accepts requests.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    req_ready = 1'b0;
    case (state_q)
      S_INIT: begin
        if (INIT_CLEAR) begin
          clr_we    = !reset;
          clr_cnt_d = clr_cnt_q + 1'b1;
          if (clr_cnt_q == IDX_W'(DEPTH_WORDS - 1)) state_d = S_RUN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN:   req_ready = !reset;
      default: state_d = S_INIT;
    endcase
  end

  assign widx = bus.address[IDX_W+1:2];
  assign oob  = |bus.address[31:IDX_W+2];

  always_comb begin
    mis   = 1'b0;
    be    = 4'b0000;
    wlane = '0;
    case (bus.funct3)
      3'b000, 3'b100: begin
        be    = 4'b0001 << bus.address[1:0];
        wlane = {4{bus.write_data[7:0]}};
      end
      3'b001, 3'b101: begin
        mis   = bus.address[0];
        be    = bus.address[1] ? 4'b1100 : 4'b0011;
        wlane = {2{bus.write_data[15:0]}};
      end
      3'b010: begin
        mis   = |bus.address[1:0];
        be    = 4'b1111;
        wlane = bus.write_data;
      end
      default: mis = 1'b1;
    endcase
  end

  assign accept  = bus.req_valid && req_ready && (bus.mem_read || bus.mem_write);
  assign st_we   = accept && bus.mem_write && !mis && !oob;
  assign rd_word = mem_q[widx];

  always_comb begin
    resp_data = '0;
    if (bus.mem_read) begin
      if (oob)       resp_data = OOB_VALUE;
      else if (!mis) resp_data = load_ext(rd_word, bus.funct3, bus.address[1:0]);
    end
  end

  // Array write port: clear sweep during INIT, byte-enabled stores in RUN.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (st_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[widx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) resp_vld_q <= 1'b0;
    else       resp_vld_q <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rdata_q <= resp_data;
      mis_q   <= mis;
      oob_q   <= oob;
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.init_done    = (state_q == S_RUN) && !reset;
  assign bus.resp_valid   = resp_vld_q && !reset;
  assign bus.read_data    = bus.resp_valid ? rdata_q : 32'h0;
  assign bus.misaligned   = bus.resp_valid && mis_q;
  assign bus.out_of_range = bus.resp_valid && oob_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: byte-array reference model, queued expectations,
// independent response monitor.
module tb_data_memory_ctrl;
  localparam int          DEPTH = 256;
  localparam logic [31:0] OOB   = 32'hDEADBEEF;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                         F_BU = 3'b100, F_HU = 3'b101;

  typedef struct packed {
    logic [31:0] data;
    logic        mis;
    logic        oob;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [7:0] ref_mem [DEPTH*4];

  data_memory_ctrl_if bus();

  data_memory_ctrl #(
    .DEPTH_WORDS (DEPTH),
    .INIT_CLEAR  (1'b1),
    .OOB_VALUE   (OOB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;
  endfunction

  // Byte-addressed reference: the load sees memory before this request's store.
  function automatic exp_t model(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd);
    exp_t   e;
    int     size;
    bit     legal;
    longint v;
    legal = 1'b1;
    case (f3)
      F_B, F_BU: size = 1;
      F_H, F_HU: size = 2;
      F_W:       size = 4;
      default: begin size = 1; legal = 1'b0; end
    endcase
    e.oob  = (addr >= 32'(DEPTH*4));
    e.mis  = !legal || ((addr % 32'(size)) != 0);
    e.data = 32'h0;
    if (rd) begin
      if (e.oob) begin
        e.data = OOB;
      end else if (!e.mis) begin
        v = 0;
        for (int i = 0; i < size; i++) v += longint'(ref_mem[addr + i]) << (8*i);
        if (!f3[2] && size < 4 && v >= (longint'(1) << (8*size - 1)))
          v -= longint'(1) << (8*size);
        e.data = v[31:0];
      end
    end
    if (wr && !e.mis && !e.oob)
      for (int i = 0; i < size; i++) ref_mem[addr + i] = wd[8*i +: 8];
    return e;
  endfunction

  // Called at posedge+1; returns at the next posedge+1 so calls chain back-to-back.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input bit v = 1'b1);
    logic rdy;
    exp_t e;
    bus.req_valid  = v;
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.funct3     = f3;
    bus.address    = addr;
    bus.write_data = wd;
    rdy = bus.req_ready;
    @(posedge clk);
    if (v && rdy && (rd || wr)) begin
      e = model(rd, wr, f3, addr, wd);
      sb_q.push_back(e);
    end
    #1;
    bus.req_valid = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  task automatic wait_init(input string nm);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (bus.req_ready) break;
      n++;
      if (n > 2000) break;
    end
    chk(nm, 32'(n), 32'd256);
    chk({nm, "_init_done"}, {31'b0, bus.init_done}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (bus.resp_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid=1 read_data=%h, required no response",
                 bus.read_data);
      end else begin
        mon_e = sb_q.pop_front();
        chk("read_data",    bus.read_data,               mon_e.data);
        chk("misaligned",   {31'b0, bus.misaligned},     {31'b0, mon_e.mis});
        chk("out_of_range", {31'b0, bus.out_of_range},   {31'b0, mon_e.oob});
      end
    end else begin
      chk("idle_read_data", bus.read_data, 32'h0);
      chk("idle_flags", {30'b0, bus.misaligned, bus.out_of_range}, 32'h0);
    end
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] addr;
    int          op;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.funct3     = 3'b000;
    bus.address    = 32'h0;
    bus.write_data = 32'h0;
    model_clear();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready",  {31'b0, bus.req_ready},  32'd0);
    chk("rst_init_done",  {31'b0, bus.init_done},  32'd0);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_init("init_cycles");

    for (int w = 0; w < DEPTH; w++) issue(1'b1, 1'b0, F_W, 32'(w*4), 32'h0);

    issue(1'b0, 1'b1, F_W,  32'h10, 32'h11223344);
    issue(1'b1, 1'b0, F_B,  32'h13, 32'h0);
    issue(1'b1, 1'b0, F_BU, 32'h13, 32'h0);
    issue(1'b1, 1'b0, F_H,  32'h12, 32'h0);
    issue(1'b1, 1'b0, F_HU, 32'h12, 32'h0);

    issue(1'b0, 1'b1, F_B,  32'h21, 32'h123456F0);
    issue(1'b1, 1'b0, F_W,  32'h20, 32'h0);
    issue(1'b1, 1'b0, F_B,  32'h21, 32'h0);
    issue(1'b1, 1'b0, F_BU, 32'h21, 32'h0);
    issue(1'b0, 1'b1, F_H,  32'h22, 32'h00008001);
    issue(1'b1, 1'b0, F_H,  32'h22, 32'h0);
    issue(1'b1, 1'b0, F_HU, 32'h22, 32'h0);

    issue(1'b1, 1'b0, F_W,    32'h22, 32'h0);
    issue(1'b0, 1'b1, F_H,    32'h05, 32'h0000BEEF);
    issue(1'b1, 1'b0, F_W,    32'h04, 32'h0);
    issue(1'b1, 1'b0, 3'b011, 32'h00, 32'h0);
    issue(1'b0, 1'b1, 3'b111, 32'h00, 32'hFFFFFFFF);
    issue(1'b1, 1'b0, F_W,    32'h00, 32'h0);

    issue(1'b1, 1'b0, F_W, 32'h400, 32'h0);
    issue(1'b0, 1'b1, F_W, 32'h400, 32'h12345678);
    issue(1'b1, 1'b0, F_W, 32'h000, 32'h0);
    issue(1'b1, 1'b0, F_H, 32'h401, 32'h0);

    issue(1'b0, 1'b1, F_W, 32'h30, 32'h01020304);
    issue(1'b1, 1'b1, F_W, 32'h30, 32'hCAFEF00D);
    issue(1'b1, 1'b0, F_W, 32'h30, 32'h0);
    issue(1'b0, 1'b0, F_W, 32'h30, 32'h0);
    issue(1'b1, 1'b0, F_W, 32'h30, 32'h0, 1'b0);

    issue(1'b0, 1'b1, F_W, 32'h08, 32'hA5A5A5A5);
    issue(1'b1, 1'b0, F_W, 32'h08, 32'h0);

    for (int i = 0; i < 600; i++) begin
      op = int'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 8) begin
        case ($urandom_range(0, 4))
          0: f3 = F_B;
          1: f3 = F_H;
          2: f3 = F_W;
          3: f3 = F_BU;
          default: f3 = F_HU;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 9) == 0) addr = 32'($urandom_range(0, 32'h7FF));
      else                           addr = 32'($urandom_range(0, 32'h3F));
      issue(op[0], op[1], f3, addr, $urandom, $urandom_range(0, 3) != 0);
    end

    issue(1'b0, 1'b1, F_W, 32'h08, 32'hA5A5A5A5);
    bus.req_valid = 1'b1;
    bus.mem_read  = 1'b1;
    bus.funct3    = F_W;
    bus.address   = 32'h08;
    @(posedge clk);
    #1;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.mem_read  = 1'b0;
    @(negedge clk);
    chk("reset_drop_resp", {31'b0, bus.resp_valid}, 32'd0);
    chk("reset_req_ready", {31'b0, bus.req_ready},  32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    wait_init("reinit_cycles");
    issue(1'b1, 1'b0, F_W, 32'h08, 32'h0);
    issue(1'b1, 1'b0, F_W, 32'h10, 32'h0);

    issue(1'b0, 1'b1, F_W, 32'h3C, 32'h77777777);
    repeat (40) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    wait_init("midinit_cycles");
    issue(1'b1, 1'b0, F_W, 32'h3FC, 32'h0);
    issue(1'b1, 1'b0, F_W, 32'h3C,  32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
